// File: rtl/write_arbiter.sv
// ---------------------------------------------------------------------------
// write_arbiter
//   Round-robin arbiter that accepts one write word at a time from up to
//   NUM_PORTS writers and presents it downstream with a valid/ready handshake.
//   Each transfer walks IDLE -> GRANT -> SEND. While a transfer is in flight,
//   every other writer sees o_busy high.
//
// Ports
//   i_clk      : single clock, rising edge
//   i_reset_n  : asynchronous active-low reset; release is synchronised inside
//   i_req      : per-port write request, bit p belongs to port p
//   i_data     : per-port write data, slice p belongs to port p
//   o_busy     : per-port busy; a low bit means that port's word is taken now
//   o_valid    : a captured word is being held for downstream
//   o_data     : captured word
//   o_port     : source port of o_data
//   i_ready    : downstream takes o_data when o_valid and i_ready are both high
//   o_count    : number of accepted words, wraps modulo 2^16
// ---------------------------------------------------------------------------
module write_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_PORTS-1:0]          i_req,
  input  logic [NUM_PORTS*DATA_W-1:0]   i_data,
  output logic [NUM_PORTS-1:0]          o_busy,
  output logic                          o_valid,
  output logic [DATA_W-1:0]             o_data,
  output logic [$clog2(NUM_PORTS)-1:0]  o_port,
  input  logic                          i_ready,
  output logic [15:0]                   o_count
);

  localparam int PW = $clog2(NUM_PORTS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  // NUM_PORTS in PW+1 bits so the wrap-around compare has no width mismatch.
  localparam logic [PW:0]   NP_W     = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0] LAST_RST = PW'(NUM_PORTS - 1);

  logic [1:0]           r_rst_sync;
  logic [1:0]           r_state;
  logic [PW-1:0]        r_grant;
  logic [PW-1:0]        r_last;
  logic [NUM_PORTS-1:0] r_busy;
  logic                 r_valid;
  logic [DATA_W-1:0]    r_data;
  logic [PW-1:0]        r_port;
  logic [15:0]          r_count;

  logic                 w_run;
  logic                 w_any_req;
  logic [PW-1:0]        w_pick;
  logic [NUM_PORTS-1:0] w_pick_mask;
  logic [DATA_W-1:0]    w_slices [NUM_PORTS];
  logic [DATA_W-1:0]    w_grant_data;
  logic                 w_grant_req;

  // First requesting port found when searching upward from last+1 with wrap.
  function automatic logic [PW-1:0] rr_pick(
    input logic [NUM_PORTS-1:0] req,
    input logic [PW-1:0]        last
  );
    logic [PW:0] idx;
    logic        found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = {1'b0, last} + (PW+1)'(k);
      if (idx >= NP_W) begin
        idx = idx - NP_W;
      end else begin
        idx = idx;
      end
      if (!found && req[idx[PW-1:0]]) begin
        rr_pick = idx[PW-1:0];
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slice
    assign w_slices[p] = i_data[p*DATA_W +: DATA_W];
  end

  // Arbitration decode: round-robin pick and the granted port's request/data.
  always_comb begin
    w_run        = r_rst_sync[1];
    w_any_req    = |i_req;
    w_pick       = rr_pick(i_req, r_last);
    w_pick_mask  = {NUM_PORTS{1'b0}};
    w_pick_mask[w_pick] = 1'b1;
    w_grant_data = w_slices[r_grant];
    w_grant_req  = i_req[r_grant];
  end

  // Two-flop reset release synchroniser; the FSM may only leave IDLE once
  // the released reset has propagated through both stages.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  // Transfer FSM with all output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= {PW{1'b0}};
      r_last  <= LAST_RST;
      r_busy  <= {NUM_PORTS{1'b1}};
      r_valid <= 1'b0;
      r_data  <= {DATA_W{1'b0}};
      r_port  <= {PW{1'b0}};
      r_count <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_run && w_any_req) begin
            r_grant <= w_pick;
            r_busy  <= ~w_pick_mask;
            r_state <= ST_GRANT;
          end else begin
            r_busy  <= {NUM_PORTS{1'b1}};
          end
        end
        ST_GRANT: begin
          r_busy <= {NUM_PORTS{1'b1}};
          // A writer that dropped its request during GRANT forfeits the slot
          // and does not advance the round-robin pointer.
          if (w_grant_req) begin
            r_data  <= w_grant_data;
            r_port  <= r_grant;
            r_valid <= 1'b1;
            r_count <= r_count + 16'd1;
            r_last  <= r_grant;
            r_state <= ST_SEND;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          r_busy <= {NUM_PORTS{1'b1}};
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= {NUM_PORTS{1'b1}};
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_port  = r_port;
  assign o_count = r_count;

endmodule
